// File: rtl/rv32_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rv32_mem_responder
// Description : Handshaked word memory slave for the RV32I fetch/load-store
//               port. Programmable response latency, byte/half/word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [31:0]           r_addr;
    logic [1:0]            r_size;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH_WORDS];

    logic                  w_accept;
    logic                  w_mem_go;
    logic                  w_op_write;
    logic [31:0]           w_op_addr;
    logic [1:0]            w_op_size;
    logic [31:0]           w_op_wdata;
    logic                  w_err;
    logic [c_ADDR_W-1:0]   w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_lane_data;

    assign req_ready = reset_n && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // With LATENCY == 1 the access edge is the acceptance edge, so the live
    // request must be used; otherwise the latched copy is.
    assign w_op_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_size  = (r_state == S_IDLE) ? req_size  : r_size;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_idx      = w_op_addr[c_ADDR_W+1:2];

    always_comb begin
        w_err = 1'b0;
        case (w_op_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = w_op_addr[0];
            2'b10:   w_err = |w_op_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if (w_op_addr[31:2] >= 30'(DEPTH_WORDS))
            w_err = 1'b1;
    end

    always_comb begin
        w_be        = 4'b1111;
        w_lane_data = w_op_wdata;
        case (w_op_size)
            2'b00: begin
                w_be        = 4'b0001 << w_op_addr[1:0];
                w_lane_data = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_mem_go = reset_n && (w_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_size  <= 2'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_mem_go) begin
                r_rdata <= (w_op_write || w_err) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_mem_go && w_op_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rv32_mem_responder
// Description : Directed self-checking bench; one responder at LATENCY 1 and
//               one at LATENCY 4 share a clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mem_responder;

    logic             clk = 1'b0;
    logic [1:0]       rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clock(clk), .reset_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    rv32_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_lat4 (
        .clock(clk), .reset_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; the bus is scrambled after acceptance so the
    // responder must be working from its latched copy.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wdata,
                       input int hold, input int exp_lat,
                       output logic [31:0] rdata, output logic err);
        int lat;
        int w;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_size[d]  = size;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b0;
        rdata = 32'hFFFF_FFFF;
        err   = 1'b1;
        w = 0;
        while (!req_ready[d] && w < 50) begin
            tick;
            w++;
        end
        if (!req_ready[d]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid[d] = 1'b0;
        end else begin
            tick;
            req_valid[d] = 1'b0;
            req_write[d] = ~wr;
            req_addr[d]  = 32'hFFFF_FFFF;
            req_size[d]  = 2'b11;
            req_wdata[d] = 32'h5A5A_5A5A;
            lat = 1;
            while (!rsp_valid[d] && lat < 50) begin
                chk("wait_req_ready", 32'(req_ready[d]), 32'd0);
                tick;
                lat++;
            end
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("rsp_req_ready", 32'(req_ready[d]), 32'd0);
            rdata = rsp_rdata[d];
            err   = rsp_err[d];
            for (int i = 0; i < hold; i++) begin
                tick;
                chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
                chk("hold_rdata", rsp_rdata[d], rdata);
                chk("hold_err", 32'(rsp_err[d]), 32'(err));
                chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
            end
            rsp_ready[d] = 1'b1;
            tick;
            rsp_ready[d] = 1'b0;
            chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("post_req_ready", 32'(req_ready[d]), 32'd1);
        end
    endtask

    task automatic b2b(input int d, input logic [31:0] addr, input int period, input int exp_acc);
        int last;
        int n_acc;
        last  = -1;
        n_acc = 0;
        req_write[d] = 1'b0;
        req_addr[d]  = addr;
        req_size[d]  = 2'b10;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid[d])
                chk("b2b_ready_in_rsp", 32'(req_ready[d]), 32'd0);
            if (req_ready[d]) begin
                if (last >= 0)
                    chk("b2b_period", 32'(c - last), 32'(period));
                last = c;
                n_acc++;
            end
            tick;
        end
        req_valid[d] = 1'b0;
        repeat (10) tick;
        rsp_ready[d] = 1'b0;
        chk("b2b_accept_count", 32'(n_acc), 32'(exp_acc));
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rst_n     = 2'b00;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        repeat (3) tick;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
        end
        rst_n = 2'b11;
        tick;
        chk("idle_ready_l1", 32'(req_ready[0]), 32'd1);
        chk("idle_ready_l4", 32'(req_ready[1]), 32'd1);

        // LATENCY 1: store, read back, partial stores
        txn(0, 1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF, 0, 1, rd, er);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 2'b10, 32'd0, 0, 1, rd, er);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_err", 32'(er), 32'd0);
        txn(0, 1'b1, 32'h12, 2'b00, 32'h0000_00AA, 0, 1, rd, er);
        chk("sb_err", 32'(er), 32'd0);
        txn(0, 1'b1, 32'h10, 2'b01, 32'h0000_1234, 0, 1, rd, er);
        chk("sh_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 2'b10, 32'd0, 0, 1, rd, er);
        chk("merge_rdata", rd, 32'hDEAA_1234);
        txn(0, 1'b1, 32'h17, 2'b00, 32'hFFFF_FF77, 0, 1, rd, er);
        txn(0, 1'b1, 32'h14, 2'b01, 32'hFFFF_9988, 2, 1, rd, er);
        txn(0, 1'b0, 32'h14, 2'b10, 32'd0, 1, 1, rd, er);
        chk("lane_top_bytes", rd & 32'hFF00_FFFF, 32'h7700_9988);

        // Error cases
        txn(0, 1'b0, 32'h11, 2'b10, 32'd0, 0, 1, rd, er);
        chk("err_lw_mis", 32'(er), 32'd1);
        chk("err_lw_mis_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h13, 2'b01, 32'h0000_FFFF, 0, 1, rd, er);
        chk("err_sh_mis", 32'(er), 32'd1);
        txn(0, 1'b1, 32'h10, 2'b11, 32'hFFFF_FFFF, 0, 1, rd, er);
        chk("err_size3", 32'(er), 32'd1);
        chk("err_size3_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h1000, 2'b10, 32'd0, 0, 1, rd, er);
        chk("err_range", 32'(er), 32'd1);
        chk("err_range_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h1010, 2'b10, 32'h0BAD_0BAD, 0, 1, rd, er);
        chk("err_range_sw", 32'(er), 32'd1);
        txn(0, 1'b0, 32'hFFC, 2'b10, 32'd0, 0, 1, rd, er);
        chk("last_word_ok", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 2'b10, 32'd0, 0, 1, rd, er);
        chk("unchanged_after_err", rd, 32'hDEAA_1234);

        // LATENCY 4 with response back-pressure
        txn(1, 1'b1, 32'h20, 2'b10, 32'h5555_5555, 5, 4, rd, er);
        chk("l4_sw_err", 32'(er), 32'd0);
        txn(1, 1'b0, 32'h20, 2'b10, 32'd0, 5, 4, rd, er);
        chk("l4_lw_rdata", rd, 32'h5555_5555);

        // Reset while the store is still in WAIT
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_size[1]  = 2'b10;
        req_wdata[1] = 32'h1111_1111;
        req_valid[1] = 1'b1;
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
        tick;
        req_valid[1] = 1'b0;
        tick;
        tick;
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready[1]), 32'd0);
        tick;
        tick;
        chk("mid_rst_valid2", 32'(rsp_valid[1]), 32'd0);
        rst_n[1] = 1'b1;
        tick;
        txn(1, 1'b0, 32'h20, 2'b10, 32'd0, 0, 4, rd, er);
        chk("mid_rst_discard", rd, 32'h5555_5555);

        // Back-to-back with req_valid held high
        b2b(1, 32'h20, 5, 6);
        b2b(0, 32'h10, 2, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rv32_mem_responder.md
Name:
rv32_mem_responder

Overview:
- Memory-side responder for the RV32I core's fetch and load/store port.
- Accepts one request at a time from the datapath through a valid/ready handshake.
- Performs word reads and byte/half/word writes with byte enables derived from the address and size.
- Returns a response after a programmable latency, holding it until the core accepts it.
- Replaces the core's flat internal memory array with a proper handshaked slave, so fetch and data stalls can be exercised.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored. Word index is req_addr[31:2].
- LATENCY, 1, cycles from request acceptance to rsp_valid rising. Legal range 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load/fetch.
- req_addr  input  32  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  full aligned word at word index; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, illegal size, or out of range.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, latency counter = 0, latched request cleared.
- req_ready is 0 while reset_n is low.
- Memory contents are not reset.
- FSM states:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch write, addr, size and wdata. Go to RESP if LATENCY == 1, otherwise go to WAIT with counter = LATENCY - 1.
  - WAIT: req_ready = 0. Decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge.
  - RESP: rsp_valid = 1, req_ready = 0. Outputs stay stable until rsp_valid && rsp_ready, then go to IDLE.
- Memory access occurs on the clock edge that enters RESP:
  - Read data is sampled into rsp_rdata on that edge.
  - The write is committed on that edge.
- Acceptance to rsp_valid = LATENCY cycles.
- One bubble cycle in IDLE after each response, so throughput is one request per LATENCY + 1 cycles.
- Write lanes:
  - Byte: lane = addr[1:0], wdata[7:0] placed in that lane.
  - Half: lane pair = addr[1], wdata[15:0] placed in that pair.
  - Word: all four lanes.
  - Untouched lanes keep their old value.
- Error conditions:
  - size 11.
  - half with addr[0] = 1.
  - word with addr[1:0] != 00.
  - addr[31:2] >= DEPTH_WORDS.
- On error: no memory write, rsp_err = 1, rsp_rdata = 0. Latency and handshake are unchanged.
- On a store, rsp_rdata = 0.
- req_* inputs are ignored outside IDLE. The core must hold them stable only until acceptance.
- rsp_ready held high in advance: the response completes in the first RESP cycle.
- rsp_ready low: rsp_valid, rsp_rdata and rsp_err remain constant indefinitely.
- Reset mid-operation: if reset asserts in WAIT, the pending write is discarded and memory is unchanged. If reset asserts in RESP, the write has already committed and the response is dropped.
- Read-after-write to the same word in back-to-back transactions returns the new data.

Test Plan:
- LATENCY = 1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> write response rsp_valid exactly 1 cycle after acceptance, rsp_err = 0. Read returns 0xDEADBEEF.
- Word 0x10 = 0xDEADBEEF. SB addr 0x12 data 0x000000AA, SH addr 0x10 data 0x00001234, then LW 0x10 -> 0xDEAA1234.
- LW 0x11, SH 0x13, req_size 11, and LW 0x1000 with DEPTH_WORDS = 1024 -> each gives rsp_err = 1, rsp_rdata = 0. Word 0x10 is unchanged on a subsequent read.
- LATENCY = 4, rsp_ready held low 5 cycles after rsp_valid -> rsp_valid rises 4 cycles after acceptance. Outputs stay stable, and req_ready stays 0 throughout. req_ready returns to 1 the cycle after the handshake.
- LATENCY = 4. SW 0x20 data 0x11111111, reset_n pulsed low 2 cycles after acceptance -> rsp_valid = 0 and req_ready = 0 during reset. After reset, LW 0x20 returns the prior contents, not 0x11111111.
- Back-to-back requests with req_valid held high -> exactly one acceptance per LATENCY + 1 cycles. No request is accepted while rsp_valid = 1.
